// File: rtl/adc_frame_align_nch.sv
// Frame-word aligner and sample assembler for NCH two-lane ADC channels, GCLK domain only.
// Optional ADC_DESER_SIGNED_EN: invert each sample MSB (offset-binary to two's complement).
module adc_frame_align_nch #(
  parameter int              NCH           = 4,
  parameter int              DESERF        = 8,
  parameter logic [DESERF-1:0] FRAME_PATTERN = 8'hF0,
  parameter int              MATCH_CNT     = 4,
  parameter int              LOSS_CNT      = 3,
  parameter int              SETTLE_CYC    = 3
) (
  input  logic                      GCLK,
  input  logic                      RESET,
  input  logic [DESERF-1:0]         FRAME_WORD,
  input  logic [NCH*2*DESERF-1:0]   LANE_DATA,
  input  logic                      RESYNC,
  output logic                      BITSLIP,
  output logic                      LOCKED,
  output logic                      ALIGN_FAIL,
  output logic [NCH*2*DESERF-1:0]   DOUT,
  output logic                      DVALID,
  output logic [7:0]                SLIP_COUNT,
  output logic [7:0]                ERR_COUNT
);

  localparam int                SW          = $clog2(DESERF + 1);
  localparam logic [3:0]        MATCH_LAST  = 4'(MATCH_CNT - 1);
  localparam logic [3:0]        LOSS_LAST   = 4'(LOSS_CNT - 1);
  localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [SW-1:0]     SRCH_LAST   = SW'(DESERF - 1);

  typedef enum logic [1:0] {S_CHECK, S_SLIP, S_SETTLE, S_LOCK} state_t;

  state_t                    r_state, w_state_nxt;
  logic [3:0]                r_match, w_match_nxt;
  logic [3:0]                r_loss, w_loss_nxt;
  logic [3:0]                r_settle, w_settle_nxt;
  logic [SW-1:0]             r_srch, w_srch_nxt;
  logic                      r_locked, w_locked_nxt;
  logic                      r_fail, w_fail_nxt;
  logic [7:0]                r_slip_cnt, w_slip_cnt_nxt;
  logic [7:0]                r_err_cnt, w_err_cnt_nxt;
  logic [NCH*2*DESERF-1:0]   r_dout, w_samples;
  logic                      r_dvalid;
  logic                      w_frame_ok;

  assign w_frame_ok = (FRAME_WORD == FRAME_PATTERN);

  always_comb begin
    // NOTE: every next-state value starts at its current value so no path infers a latch.
    w_state_nxt    = r_state;
    w_match_nxt    = r_match;
    w_loss_nxt     = r_loss;
    w_settle_nxt   = r_settle;
    w_srch_nxt     = r_srch;
    w_locked_nxt   = r_locked;
    w_fail_nxt     = r_fail;
    w_slip_cnt_nxt = r_slip_cnt;
    w_err_cnt_nxt  = r_err_cnt;
    if (RESYNC) begin
      w_state_nxt  = S_CHECK;
      w_match_nxt  = '0;
      w_loss_nxt   = '0;
      w_settle_nxt = '0;
      w_srch_nxt   = '0;
      w_locked_nxt = 1'b0;
      w_fail_nxt   = 1'b0;
    end else begin
      unique case (r_state)
        S_CHECK: begin
          if (!w_frame_ok) begin
            w_match_nxt = '0;
            w_state_nxt = S_SLIP;
          end else if (r_match == MATCH_LAST) begin
            w_match_nxt  = '0;
            w_locked_nxt = 1'b1;
            w_state_nxt  = S_LOCK;
          end else begin
            w_match_nxt = r_match + 4'd1;
          end
        end
        S_SLIP: begin
          if (r_slip_cnt != 8'hFF) w_slip_cnt_nxt = r_slip_cnt + 8'd1;
          // A full rotation without lock flags failure but the search keeps going.
          if (r_srch == SRCH_LAST) begin
            w_srch_nxt = '0;
            w_fail_nxt = 1'b1;
          end else begin
            w_srch_nxt = r_srch + 1'b1;
          end
          w_settle_nxt = '0;
          w_state_nxt  = S_SETTLE;
        end
        S_SETTLE: begin
          if (r_settle == SETTLE_LAST) begin
            w_settle_nxt = '0;
            w_match_nxt  = '0;
            w_state_nxt  = S_CHECK;
          end else begin
            w_settle_nxt = r_settle + 4'd1;
          end
        end
        S_LOCK: begin
          if (w_frame_ok) begin
            w_loss_nxt = '0;
          end else if (r_loss == LOSS_LAST) begin
            w_loss_nxt   = '0;
            w_srch_nxt   = '0;
            w_locked_nxt = 1'b0;
            if (r_err_cnt != 8'hFF) w_err_cnt_nxt = r_err_cnt + 8'd1;
            w_state_nxt  = S_CHECK;
          end else begin
            w_loss_nxt = r_loss + 4'd1;
          end
        end
        default: w_state_nxt = S_CHECK;
      endcase
    end
  end

  always_ff @(posedge GCLK or posedge RESET) begin
    if (RESET) begin
      r_state    <= S_CHECK;
      r_match    <= '0;
      r_loss     <= '0;
      r_settle   <= '0;
      r_srch     <= '0;
      r_locked   <= 1'b0;
      r_fail     <= 1'b0;
      r_slip_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      r_state    <= w_state_nxt;
      r_match    <= w_match_nxt;
      r_loss     <= w_loss_nxt;
      r_settle   <= w_settle_nxt;
      r_srch     <= w_srch_nxt;
      r_locked   <= w_locked_nxt;
      r_fail     <= w_fail_nxt;
      r_slip_cnt <= w_slip_cnt_nxt;
      r_err_cnt  <= w_err_cnt_nxt;
    end
  end

  // Lane 0 supplies the odd sample bits, lane 1 the even ones.
  always_comb begin
    w_samples = '0;
    for (int c = 0; c < NCH; c++) begin
      for (int i = 0; i < DESERF; i++) begin
        w_samples[c*2*DESERF + 2*i + 1] = LANE_DATA[(2*c)*DESERF + i];
        w_samples[c*2*DESERF + 2*i]     = LANE_DATA[(2*c+1)*DESERF + i];
      end
`ifdef ADC_DESER_SIGNED_EN
      w_samples[c*2*DESERF + 2*DESERF - 1] = ~LANE_DATA[(2*c)*DESERF + DESERF - 1];
`endif
    end
  end

  // Valid follows the lock flag being written on the same edge, so it drops with LOCKED.
  always_ff @(posedge GCLK or posedge RESET) begin
    if (RESET) begin
      r_dout   <= '0;
      r_dvalid <= 1'b0;
    end else begin
      r_dvalid <= w_locked_nxt;
      r_dout   <= w_locked_nxt ? w_samples : '0;
    end
  end

  assign BITSLIP    = (r_state == S_SLIP);
  assign LOCKED     = r_locked;
  assign ALIGN_FAIL = r_fail;
  assign SLIP_COUNT = r_slip_cnt;
  assign ERR_COUNT  = r_err_cnt;
  assign DOUT       = r_dout;
  assign DVALID     = r_dvalid;

endmodule

// File: doc/adc_frame_align_nch.md
Name: adc_frame_align_nch

Overview:
- Fabric-side successor to the fixed 4-channel DDR deserializer.
- Takes per-lane parallel words from NCH channels of serializer primitives (LANES=2 per channel), plus the frame-clock word.
- Drives the shared bitslip until the frame word matches FRAME_PATTERN, then assembles SAMPLE_W-bit samples per channel with a valid flag.
- Adds lock-loss detection, resync, slip and error counters; runs entirely in the GCLK domain.

Parameters:
- NCH, 4, number of ADC channels (1..16)
- DESERF, 8, bits per lane word per GCLK
- FRAME_PATTERN, 8'hF0, expected frame word when aligned (DESERF bits)
- MATCH_CNT, 4, consecutive matching frame words required to lock (1..15)
- LOSS_CNT, 3, consecutive mismatches in LOCKED before lock is dropped (1..15)
- SETTLE_CYC, 3, idle cycles after each bitslip pulse before re-checking (1..15)

Ports:
- GCLK  in  1  fabric clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- FRAME_WORD  in  DESERF  deserialized frame-clock word, bit DESERF-1 received first
- LANE_DATA  in  NCH*2*DESERF  channel c lane l at bits [(2c+l)*DESERF +: DESERF]
- RESYNC  in  1  one-cycle request to restart alignment
- BITSLIP  out  1  one-cycle pulse to all serializers (frame and data)
- LOCKED  out  1  frame aligned
- ALIGN_FAIL  out  1  sticky: DESERF slips done without reaching lock
- DOUT  out  NCH*2*DESERF  channel c sample at bits [c*2*DESERF +: 2*DESERF]
- DVALID  out  1  DOUT valid this cycle
- SLIP_COUNT  out  8  total bitslip pulses, saturating
- ERR_COUNT  out  8  lock-loss events, saturating

Behaviour:
- Reset values:
  - all outputs 0
  - FSM state CHECK
  - match, loss and settle counters 0
  - per-search slip counter 0
- FSM states: CHECK, SLIP, SETTLE, LOCK.
- CHECK:
  - FRAME_WORD==FRAME_PATTERN: increment match counter; when it reaches MATCH_CNT, go to LOCK and set LOCKED on that edge.
  - Mismatch: clear match counter, go to SLIP.
- SLIP:
  - BITSLIP=1 for exactly this one cycle.
  - SLIP_COUNT +1, saturates at 255.
  - Per-search slip counter +1; when it reaches DESERF it wraps to 0 and sets ALIGN_FAIL. Search continues.
  - Next state SETTLE.
- SETTLE: wait SETTLE_CYC cycles with BITSLIP=0, then CHECK with match counter 0.
- LOCK:
  - Each mismatch increments the loss counter; any match clears it.
  - When the loss counter reaches LOSS_CNT: ERR_COUNT +1 (saturating), LOCKED=0, per-search slip counter cleared, go to CHECK.
- RESYNC=1 in any state:
  - Next state CHECK; all internal counters cleared; LOCKED=0.
  - ALIGN_FAIL cleared; SLIP_COUNT and ERR_COUNT kept.
  - RESYNC has priority over every other transition.
- A new search (entry to CHECK from LOCK or RESYNC) clears ALIGN_FAIL only via RESYNC. Lock loss leaves it set.
- Sample assembly, for channel c with lane0 word A and lane1 word B (each DESERF bits):
  - sample[2i+1]=A[i], sample[2i]=B[i], for i=0..DESERF-1.
  - Lane 0 carries the odd (upper-interleaved) bits.
- Output timing:
  - DOUT and DVALID are registered, 1 GCLK latency from LANE_DATA.
  - DVALID = LOCKED state at the sampling edge.
  - When DVALID=0, DOUT is forced to 0.
- The cycle LOCKED falls, DVALID falls with it, and DOUT=0 on the same edge.
- Words present during the BITSLIP pulse and SETTLE are never marked valid.

Optional Feature:
- Macro: ADC_DESER_SIGNED_EN.
- Defined: each assembled sample has its MSB inverted before the output register, converting offset-binary to two's complement. Latency unchanged.
- Undefined: samples output as offset binary, unmodified.

Test Plan:
- Frame word presented already equal to 8'hF0 after reset → LOCKED=1 on the 4th cycle, BITSLIP never pulses, SLIP_COUNT=0.
- Model frame rotated by 3 bits, rotating one position per BITSLIP → exactly 3 single-cycle BITSLIP pulses, each followed by 3 idle cycles. Then LOCKED=1; SLIP_COUNT=3, ALIGN_FAIL=0.
- Frame stuck at 8'h00 → after 8 slips ALIGN_FAIL=1, slipping continues, SLIP_COUNT saturates at 255.
- Locked, lane0=8'hFF and lane1=8'h00 on channel 2 → next cycle that channel's DOUT=16'hAAAA with DVALID=1.
  - With ADC_DESER_SIGNED_EN defined, DOUT=16'h2AAA.
- Locked, inject 2 bad frame words then a good one → stays locked. Then inject 3 bad words → LOCKED and DVALID drop on the 3rd, ERR_COUNT=1.
- Assert RESYNC while in LOCK with ALIGN_FAIL previously set → next cycle LOCKED=0, ALIGN_FAIL=0, SLIP_COUNT unchanged. Relock after 4 good words.
